// File: rtl/tpu_pkg.sv
// tpu_pkg: shared state/target enums and bus widths for the DMA decoder, memories and sequencer
package tpu_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
    typedef enum logic [1:0] {TGT_W, TGT_INP, TGT_INS} target_e;
endpackage

// File: rtl/dma_load_sequencer.sv
// dma_load_sequencer: turns decoded DMA commands into memory-write bursts and gated core launches
module dma_load_sequencer #(
    parameter int DATA_W    = tpu_pkg::DATA_W,
    parameter int ADDR_W    = tpu_pkg::ADDR_W,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              fetch_w,
    input  logic              fetch_inp,
    input  logic              fetch_ins,
    input  logic              start,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              core_done,
    output logic              w_we,
    output logic              inp_we,
    output logic              ins_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import tpu_pkg::*;

    state_e            state_q, state_d;
    target_e           tgt_q, tgt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [2:0]        loaded_q, loaded_d;
    logic [2:0]        we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_start_q, core_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        nfields;
    logic              last_word;

    assign nfields   = 3'(fetch_w) + 3'(fetch_inp) + 3'(fetch_ins) + 3'(start);
    assign last_word = cnt_q == (ADDR_W+1)'(BURST_LEN - 1);

    // Next-state and registered-output decode; commands are only honoured in IDLE
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        loaded_d     = loaded_q;
        we_d         = '0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && nfields == 3'd1 && !start) begin
                    tgt_d  = fetch_w ? TGT_W : fetch_inp ? TGT_INP : TGT_INS;
                    base_d = dma_address;
                    cnt_d  = '0;
                    loaded_d[tgt_d] = 1'b0;
                    state_d = LOAD;
                end else if (cmd_valid && nfields == 3'd1) begin
                    core_start_d = &loaded_q;
                    err_d        = ~&loaded_q;
                    state_d      = &loaded_q ? RUN : IDLE;
                end else begin
                    err_d = cmd_valid && nfields > 3'd1;
                end
            end
            LOAD: begin
                err_d = cmd_valid;
                if (data_valid) begin
                    we_d    = 3'(1) << tgt_q;
                    addr_d  = base_q + cnt_q[ADDR_W-1:0];
                    wdata_d = data_in;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_word) begin
                        loaded_d[tgt_q] = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                err_d = cmd_valid;
                if (core_done) begin
                    done_d = 1'b1;
                    loaded_d[TGT_INP] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // busy must also cover the cycle that carries the final burst write
        busy_d = state_d != IDLE || state_q == LOAD;
    end

    // State, burst bookkeeping and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tgt_q        <= TGT_W;
            base_q       <= '0;
            cnt_q        <= '0;
            loaded_q     <= '0;
            we_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            loaded_q     <= loaded_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign w_we       = we_q[TGT_W];
    assign inp_we     = we_q[TGT_INP];
    assign ins_we     = we_q[TGT_INS];
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_dma_load_sequencer.sv
// tb_dma_load_sequencer: directed checks of bursts, start gating, error pulses and reset
module tb_dma_load_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, fetch_w = 1'b0, fetch_inp = 1'b0, fetch_ins = 1'b0, start = 1'b0;
    logic [5:0] dma_address = '0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       core_done = 1'b0;
    logic       w_we, inp_we, ins_we, core_start, busy, done, err;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    int         n_chk = 0;
    int         n_fail = 0;

    dma_load_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .fetch_w(fetch_w),
        .fetch_inp(fetch_inp), .fetch_ins(fetch_ins), .start(start),
        .dma_address(dma_address), .data_valid(data_valid), .data_in(data_in),
        .core_done(core_done), .w_we(w_we), .inp_we(inp_we), .ins_we(ins_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_start(core_start),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // f = {fetch_w, fetch_inp, fetch_ins, start}; one-cycle cmd_valid
    task automatic cmd(input logic [3:0] f, input logic [5:0] a);
        {fetch_w, fetch_inp, fetch_ins, start} = f;
        dma_address = a;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        {fetch_w, fetch_inp, fetch_ins, start} = '0;
    endtask

    // tgt: 0=W 1=INP 2=INS; err_at: word index carrying a stray fetch command (-1 none)
    task automatic burst(input int tgt, input logic [5:0] base, input logic [7:0] d0,
                         input int gap, input int err_at, input int nwords);
        logic [2:0] we_exp;
        we_exp = 3'(1) << tgt;
        cmd(tgt == 0 ? 4'b1000 : tgt == 1 ? 4'b0100 : 4'b0010, base);
        chk("cmd_err", {31'd0, err}, 0);
        chk("cmd_busy", {31'd0, busy}, 1);
        for (int i = 0; i < nwords; i++) begin
            data_valid = 1'b1;
            data_in = d0 + 8'(i);
            if (i == err_at) begin
                cmd_valid = 1'b1;
                fetch_inp = 1'b1;
            end
            tick();
            data_valid = 1'b0;
            cmd_valid = 1'b0;
            fetch_inp = 1'b0;
            chk("we", {29'd0, ins_we, inp_we, w_we}, {29'd0, we_exp});
            chk("addr", {26'd0, mem_addr}, {26'd0, 6'(base + 6'(i))});
            chk("wdata", {24'd0, mem_wdata}, {24'd0, 8'(d0 + 8'(i))});
            chk("busy_burst", {31'd0, busy}, 1);
            chk("err_burst", {31'd0, err}, (i == err_at) ? 32'd1 : 32'd0);
            for (int g = 0; g < gap && i < nwords - 1; g++) begin
                tick();
                chk("gap_we", {29'd0, ins_we, inp_we, w_we}, 0);
            end
        end
        if (nwords == 16) begin
            tick();
            chk("post_busy", {31'd0, busy}, 0);
            chk("post_we", {29'd0, ins_we, inp_we, w_we}, 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {18'd0, w_we, inp_we, ins_we, mem_addr, mem_wdata, core_start, busy, done, err}, 0);
    endtask

    task automatic run_core(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            data_valid = 1'b1;
            tick();
            chk("run_busy", {31'd0, busy}, 1);
            chk("run_drop", {29'd0, ins_we, inp_we, w_we}, 0);
        end
        data_valid = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done", {31'd0, done}, 1);
        chk("done_busy", {31'd0, busy}, 0);
        tick();
        chk("done_pulse", {31'd0, done}, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b1;
        tick();
        chk_zero("idle");
        cmd(4'b0000, 6'h00);
        chk("nop_err", {31'd0, err}, 0);
        cmd(4'b1100, 6'h00);
        chk("multi_err", {31'd0, err}, 1);
        chk("multi_busy", {31'd0, busy}, 0);
        burst(0, 6'h3C, 8'h01, 0, -1, 16);
        cmd(4'b0001, 6'h00);
        chk("start_w_only_err", {31'd0, err}, 1);
        chk("start_w_only_cs", {31'd0, core_start}, 0);
        tick();
        chk("start_w_only_busy", {31'd0, busy}, 0);
        burst(1, 6'h10, 8'h20, 0, -1, 16);
        burst(2, 6'h00, 8'h40, 1, -1, 16);
        cmd(4'b0001, 6'h00);
        chk("start_cs", {31'd0, core_start}, 1);
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_err", {31'd0, err}, 0);
        tick();
        chk("start_cs_pulse", {31'd0, core_start}, 0);
        cmd(4'b0100, 6'h00);
        chk("run_cmd_err", {31'd0, err}, 1);
        run_core(18);
        cmd(4'b0001, 6'h00);
        chk("restart_err", {31'd0, err}, 1);
        chk("restart_cs", {31'd0, core_start}, 0);
        burst(1, 6'h20, 8'h60, 0, -1, 16);
        cmd(4'b0001, 6'h00);
        chk("reload_cs", {31'd0, core_start}, 1);
        run_core(3);
        burst(0, 6'h08, 8'h80, 3, 5, 16);
        burst(2, 6'h30, 8'hA0, 0, -1, 7);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        #2;
        reset = 1'b1;
        tick();
        chk_zero("after_reset");
        cmd(4'b0001, 6'h00);
        chk("reset_start_err", {31'd0, err}, 1);
        chk("reset_start_cs", {31'd0, core_start}, 0);
        burst(2, 6'h05, 8'hC0, 0, -1, 16);
        cmd(4'b0001, 6'h00);
        chk("ins_only_err", {31'd0, err}, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
